// File: rtl/mc_cpu_control.sv
// Multi-cycle MIPS control FSM with memory wait states and latched interrupts.
// Define IRQ_VECTOR_EN for per-line IRQ priority; the default ORs all lines.
module mc_cpu_control #(
  parameter int IRQ_W  = 4,
  parameter int XP_REG = 26,
  parameter int RA_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruct,
  input  logic             PC_sv,
  input  logic [IRQ_W-1:0] IRQ,
  input  logic             MemReady,
  input  logic             Zero,
  output logic             PCWr,
  output logic             IRWr,
  output logic             IorD,
  output logic             MemRd,
  output logic             MemWr,
  output logic             RegWr,
  output logic [2:0]       PCSrc,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             ALUSrc1,
  output logic [1:0]       ALUSrc2,
  output logic [5:0]       ALUFun,
  output logic             Sign,
  output logic             EXTOp,
  output logic             LUOp,
  output logic [3:0]       Cause,
  output logic [2:0]       State
);

  if (IRQ_W < 1 || IRQ_W > 8 ||
      RA_REG > 31 || XP_REG > 31) begin : g_bad_param
    $error("mc_cpu_control: bad parameter");
  end

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [5:0] F_ADD = 6'b000000;
  localparam logic [5:0] F_SUB = 6'b000001;
  localparam logic [5:0] F_AND = 6'b011000;
  localparam logic [5:0] F_OR  = 6'b011110;
  localparam logic [5:0] F_XOR = 6'b010110;
  localparam logic [5:0] F_NOR = 6'b010001;
  localparam logic [5:0] F_SLL = 6'b100000;
  localparam logic [5:0] F_SRL = 6'b100001;
  localparam logic [5:0] F_SRA = 6'b100011;
  localparam logic [5:0] F_EQ  = 6'b110011;
  localparam logic [5:0] F_LT  = 6'b110101;

  logic [2:0]       state, nxt;
  logic [3:0]       cause, cause_d;
  logic [IRQ_W-1:0] pend, clr_mask, clr;
  logic [1:0]       cause_idx;
  logic             ill, go_fetch;

  logic [5:0] op, funct;
  logic is_r, is_j, is_jal, is_jr, is_jalr, is_jmp;
  logic is_br, is_lw, is_sw, is_mem, is_imm;
  logic is_nop, r_ok, legal;

  assign op      = Instruct[31:26];
  assign funct   = Instruct[5:0];
  assign is_r    = op == 6'h00;
  assign is_j    = op == 6'h02;
  assign is_jal  = op == 6'h03;
  assign is_br   = op == 6'h04 || op == 6'h05;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2b;
  assign is_mem  = is_lw || is_sw;
  assign is_imm  = op inside {[6'h08:6'h0f]};
  assign is_jr   = is_r && funct == 6'h08;
  assign is_jalr = is_r && funct == 6'h09;
  assign is_jmp  = is_j || is_jal || is_jr || is_jalr;
  assign is_nop  = Instruct == 32'h0;
  assign r_ok    = funct inside {6'h00, 6'h02, 6'h03,
                                 6'h08, 6'h09, [6'h20:6'h27],
                                 6'h2a, 6'h2b};
  assign legal   = (is_r && r_ok) || is_j || is_jal ||
                   is_br || is_imm || is_mem;

`ifdef IRQ_VECTOR_EN
  logic [2:0] pick, tidx;

  always_comb begin
    pick = '0;
    for (int i = IRQ_W - 1; i >= 0; i--)
      if (pend[i]) pick = 3'(i);
  end

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < IRQ_W; i++)
      clr_mask[i] = tidx == 3'(i);
  end

  always_ff @(posedge clk) begin
    if (!reset) tidx <= '0;
    else if (nxt == S_TRAP) tidx <= pick;
  end

  assign cause_idx = pick[1:0];
`else
  assign clr_mask  = '1;
  assign cause_idx = 2'b00;
`endif

  assign cause_d = ill ? 4'b1100 : {2'b10, cause_idx};
  // Illegal-op traps leave pending interrupts untouched.
  assign clr = (state == S_TRAP && !cause[2]) ? clr_mask : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
      cause <= '0;
      pend  <= '0;
    end else begin
      state <= nxt;
      pend  <= (pend & ~clr) | IRQ;
      if (nxt == S_TRAP) cause <= cause_d;
    end
  end

  always_comb begin
    nxt      = state;
    ill      = 1'b0;
    go_fetch = 1'b0;
    unique case (state)
      S_FETCH:  if (MemReady) nxt = S_DECODE;
      S_DECODE: begin
        if (!legal && !PC_sv) ill = 1'b1;
        else if (!legal || is_nop || is_jmp) go_fetch = 1'b1;
        else nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_br) go_fetch = 1'b1;
        else if (is_mem) nxt = S_MEM;
        else nxt = S_WB;
      end
      S_MEM: begin
        if (MemReady) begin
          if (is_sw) go_fetch = 1'b1;
          else nxt = S_WB;
        end
      end
      S_WB:    go_fetch = 1'b1;
      default: nxt = S_FETCH;
    endcase
    if (ill) nxt = S_TRAP;
    else if (go_fetch)
      nxt = (pend != '0 && !PC_sv) ? S_TRAP : S_FETCH;
  end

  logic [5:0] a_fun;
  logic [1:0] a_src2;
  logic       a_src1, a_sgn, a_ext, a_lu;

  always_comb begin
    a_fun  = F_ADD;
    a_src1 = 1'b0;
    a_src2 = 2'b00;
    a_sgn  = 1'b0;
    a_ext  = 1'b0;
    a_lu   = 1'b0;
    unique case (1'b1)
      is_r: begin
        case (funct)
          6'h20:   begin a_fun = F_ADD; a_sgn = 1'b1; end
          6'h22:   begin a_fun = F_SUB; a_sgn = 1'b1; end
          6'h23:   a_fun = F_SUB;
          6'h24:   a_fun = F_AND;
          6'h25:   a_fun = F_OR;
          6'h26:   a_fun = F_XOR;
          6'h27:   a_fun = F_NOR;
          6'h2a:   begin a_fun = F_LT; a_sgn = 1'b1; end
          6'h2b:   a_fun = F_LT;
          6'h00:   begin a_fun = F_SLL; a_src1 = 1'b1; end
          6'h02:   begin a_fun = F_SRL; a_src1 = 1'b1; end
          6'h03:   begin a_fun = F_SRA; a_src1 = 1'b1; end
          default: a_fun = F_ADD;
        endcase
      end
      is_imm: begin
        a_src2 = 2'b01;
        case (op)
          6'h08:   begin a_sgn = 1'b1; a_ext = 1'b1; end
          6'h09:   a_ext = 1'b1;
          6'h0a:   begin
            a_fun = F_LT; a_sgn = 1'b1; a_ext = 1'b1;
          end
          6'h0b:   begin a_fun = F_LT; a_ext = 1'b1; end
          6'h0c:   a_fun = F_AND;
          6'h0d:   a_fun = F_OR;
          6'h0e:   a_fun = F_XOR;
          default: a_lu = 1'b1;
        endcase
      end
      is_mem: begin a_src2 = 2'b01; a_ext = 1'b1; end
      // bne compares for equality so Zero=1 means "not equal".
      is_br: begin
        a_ext = 1'b1;
        a_fun = (op == 6'h04) ? F_SUB : F_EQ;
      end
      default: ;
    endcase
  end

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    IorD     = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    PCSrc    = 3'b000;
    RegDst   = 2'b00;
    MemToReg = 2'b00;
    ALUSrc1  = 1'b0;
    ALUSrc2  = 2'b00;
    ALUFun   = 6'b0;
    Sign     = 1'b0;
    EXTOp    = 1'b0;
    LUOp     = 1'b0;
    if (reset) begin
      unique case (state)
        S_FETCH: begin
          MemRd   = 1'b1;
          ALUSrc2 = 2'b10;
          IRWr    = MemReady;
          PCWr    = MemReady;
        end
        S_DECODE: begin
          if (is_jmp) begin
            PCWr  = 1'b1;
            PCSrc = (is_jr || is_jalr) ? 3'b011 : 3'b010;
          end
          if (is_jal || is_jalr) begin
            RegWr    = 1'b1;
            RegDst   = 2'b10;
            MemToReg = 2'b10;
          end
        end
        S_EXEC: begin
          ALUFun  = a_fun;
          ALUSrc1 = a_src1;
          ALUSrc2 = a_src2;
          Sign    = a_sgn;
          EXTOp   = a_ext;
          LUOp    = a_lu;
          if (is_br) begin
            PCWr  = Zero;
            PCSrc = 3'b001;
          end
        end
        S_MEM: begin
          IorD  = 1'b1;
          MemRd = is_lw;
          MemWr = is_sw;
        end
        S_WB: begin
          RegWr    = 1'b1;
          RegDst   = is_r ? 2'b00 : 2'b01;
          MemToReg = is_lw ? 2'b01 : 2'b00;
        end
        S_TRAP: begin
          PCWr     = 1'b1;
          RegWr    = 1'b1;
          RegDst   = 2'b11;
          MemToReg = 2'b10;
          PCSrc    = cause[2] ? 3'b101 : 3'b100;
        end
        default: ;
      endcase
    end
  end

  assign Cause = cause;
  assign State = state;

endmodule

// File: tb/tb_mc_cpu_control.sv
// Directed bench for mc_cpu_control: instruction table plus
// hand-written stall, interrupt, illegal-op and reset sequences.
module tb_mc_cpu_control;

  localparam int IRQ_W = 4;
  localparam logic [2:0] FETCH = 3'd0;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] MEM   = 3'd3;
  localparam logic [2:0] TRAP  = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, PC_sv, MemReady, Zero;
  logic [31:0] Instruct;
  logic [IRQ_W-1:0] IRQ;
  logic PCWr, IRWr, IorD, MemRd, MemWr, RegWr;
  logic [2:0] PCSrc, State;
  logic [1:0] RegDst, MemToReg, ALUSrc2;
  logic ALUSrc1, Sign, EXTOp, LUOp;
  logic [5:0] ALUFun;
  logic [3:0] Cause;

  mc_cpu_control #(.IRQ_W(IRQ_W)) dut (
    .clk(clk), .reset(reset), .Instruct(Instruct),
    .PC_sv(PC_sv), .IRQ(IRQ), .MemReady(MemReady),
    .Zero(Zero), .PCWr(PCWr), .IRWr(IRWr), .IorD(IorD),
    .MemRd(MemRd), .MemWr(MemWr), .RegWr(RegWr),
    .PCSrc(PCSrc), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUFun(ALUFun),
    .Sign(Sign), .EXTOp(EXTOp), .LUOp(LUOp),
    .Cause(Cause), .State(State)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  int cycles, n_rw, n_pc, n_mem, n_irwr;
  logic [2:0] rw_st, pc_src, last_st;
  logic [1:0] rw_dst, rw_m2r, ex_s2;
  logic [5:0] ex_fun;
  logic ex_s1, ex_sgn, ex_ext, ex_lu;
  logic [31:0] seq;

  // Runs one instruction from the current FETCH negedge; returns at the
  // negedge where the FSM is back in FETCH or has entered TRAP.
  task automatic run(input logic [31:0] ir, input logic z,
                     input logic sv, input int fst, input int mst,
                     input int irq_at, input logic [IRQ_W-1:0] irq_v);
    int fs, ms;
    logic left, done;
    Instruct = ir; Zero = z; PC_sv = sv;
    cycles = 0; n_rw = 0; n_pc = 0; n_mem = 0; n_irwr = 0;
    rw_st = 0; rw_dst = 0; rw_m2r = 0; pc_src = 0;
    ex_fun = 0; ex_s1 = 0; ex_s2 = 0;
    ex_sgn = 0; ex_ext = 0; ex_lu = 0;
    seq = 0; fs = 0; ms = 0; left = 0; done = 0;
    for (int k = 0; k < 64; k++) begin
      MemReady = 1'b1;
      if (State == FETCH && fs < fst) begin
        MemReady = 1'b0; fs++;
      end
      if (State == MEM && ms < mst) begin
        MemReady = 1'b0; ms++;
      end
      IRQ = (cycles == irq_at) ? irq_v : '0;
      #1;
      seq = {seq[27:0], 1'b0, State};
      if (State != FETCH) left = 1'b1;
      if (RegWr) begin
        n_rw++; rw_st = State; rw_dst = RegDst; rw_m2r = MemToReg;
      end
      if (State != FETCH && PCWr) begin
        n_pc++; pc_src = PCSrc;
      end
      if (State == FETCH && IRWr) n_irwr++;
      if (State == EXEC) begin
        ex_fun = ALUFun; ex_s1 = ALUSrc1; ex_s2 = ALUSrc2;
        ex_sgn = Sign; ex_ext = EXTOp; ex_lu = LUOp;
      end
      if (State == MEM && IorD && (MemRd || MemWr)) n_mem++;
      cycles++;
      @(negedge clk);
      if (left && (State == FETCH || State == TRAP)) begin
        done = 1'b1;
        break;
      end
    end
    IRQ = '0;
    last_st = State;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: got %0d cycles want return to FETCH", cycles);
    end
  endtask

  typedef struct {
    string nm;
    logic [31:0] ir;
    logic z;
    logic sv;
    int cyc;
    logic [5:0] fun;
    logic s1;
    logic [1:0] s2;
    logic sgn;
    logic ext;
    logic lu;
    int nrw;
    logic [2:0] rws;
    logic [1:0] dst;
    logic [1:0] m2r;
    int npc;
    logic [2:0] psrc;
  } vec_t;

  vec_t v[19];

`ifdef IRQ_VECTOR_EN
  localparam logic [3:0] C_IRQ1 = 4'b1001;
  localparam logic [2:0] L_NOP  = 3'd5;
`else
  localparam logic [3:0] C_IRQ1 = 4'b1000;
  localparam logic [2:0] L_NOP  = 3'd0;
`endif

  localparam logic [31:0] I_ADD = 32'h00221820;
  localparam logic [31:0] I_LW  = 32'h8C220004;
  localparam logic [31:0] I_SW  = 32'hAC220004;

  initial begin
    v[0]  = '{"add",   I_ADD,        0,0,4,6'b000000,0,2'b00,1,0,0,1,4,2'b00,2'b00,0,3'b000};
    v[1]  = '{"sub",   32'h00221822, 0,0,4,6'b000001,0,2'b00,1,0,0,1,4,2'b00,2'b00,0,3'b000};
    v[2]  = '{"or",    32'h00221825, 0,0,4,6'b011110,0,2'b00,0,0,0,1,4,2'b00,2'b00,0,3'b000};
    v[3]  = '{"sll",   32'h00021900, 0,0,4,6'b100000,1,2'b00,0,0,0,1,4,2'b00,2'b00,0,3'b000};
    v[4]  = '{"slt",   32'h0022182A, 0,0,4,6'b110101,0,2'b00,1,0,0,1,4,2'b00,2'b00,0,3'b000};
    v[5]  = '{"addi",  32'h20220005, 0,0,4,6'b000000,0,2'b01,1,1,0,1,4,2'b01,2'b00,0,3'b000};
    v[6]  = '{"ori",   32'h342200FF, 0,0,4,6'b011110,0,2'b01,0,0,0,1,4,2'b01,2'b00,0,3'b000};
    v[7]  = '{"lui",   32'h3C021234, 0,0,4,6'b000000,0,2'b01,0,0,1,1,4,2'b01,2'b00,0,3'b000};
    v[8]  = '{"lw",    I_LW,         0,0,5,6'b000000,0,2'b01,0,1,0,1,4,2'b01,2'b01,0,3'b000};
    v[9]  = '{"sw",    I_SW,         0,0,4,6'b000000,0,2'b01,0,1,0,0,0,2'b00,2'b00,0,3'b000};
    v[10] = '{"beq_t", 32'h10220003, 1,0,3,6'b000001,0,2'b00,0,1,0,0,0,2'b00,2'b00,1,3'b001};
    v[11] = '{"beq_n", 32'h10220003, 0,0,3,6'b000001,0,2'b00,0,1,0,0,0,2'b00,2'b00,0,3'b000};
    v[12] = '{"bne_t", 32'h14220003, 1,0,3,6'b110011,0,2'b00,0,1,0,0,0,2'b00,2'b00,1,3'b001};
    v[13] = '{"j",     32'h08000010, 0,0,2,6'b000000,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,3'b010};
    v[14] = '{"jal",   32'h0C000010, 0,0,2,6'b000000,0,2'b00,0,0,0,1,1,2'b10,2'b10,1,3'b010};
    v[15] = '{"jr",    32'h03E00008, 0,0,2,6'b000000,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,3'b011};
    v[16] = '{"jalr",  32'h0040F809, 0,0,2,6'b000000,0,2'b00,0,0,0,1,1,2'b10,2'b10,1,3'b011};
    v[17] = '{"nop",   32'h00000000, 0,0,2,6'b000000,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,3'b000};
    v[18] = '{"ill_sv",32'hFC000000, 0,1,2,6'b000000,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,3'b000};

    reset = 1'b0; Instruct = '0; PC_sv = 1'b0;
    IRQ = '0; MemReady = 1'b1; Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(State), 32'(FETCH));
    chk("rst_outs", 32'({PCWr, IRWr, IorD, MemRd, MemWr, RegWr,
                         PCSrc, RegDst, MemToReg, ALUSrc1, ALUSrc2,
                         ALUFun, Sign, EXTOp, LUOp}), 32'h0);
    chk("rst_cause", 32'(Cause), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run(v[i].ir, v[i].z, v[i].sv, 0, 0, -1, '0);
      chk({v[i].nm, "_cycles"}, 32'(cycles), 32'(v[i].cyc));
      chk({v[i].nm, "_end"}, 32'(last_st), 32'(FETCH));
      chk({v[i].nm, "_nregwr"}, 32'(n_rw), 32'(v[i].nrw));
      chk({v[i].nm, "_npcwr"}, 32'(n_pc), 32'(v[i].npc));
      if (v[i].nrw > 0) begin
        chk({v[i].nm, "_rw_state"}, 32'(rw_st), 32'(v[i].rws));
        chk({v[i].nm, "_regdst"}, 32'(rw_dst), 32'(v[i].dst));
        chk({v[i].nm, "_memtoreg"}, 32'(rw_m2r), 32'(v[i].m2r));
      end
      if (v[i].npc > 0)
        chk({v[i].nm, "_pcsrc"}, 32'(pc_src), 32'(v[i].psrc));
      if (v[i].cyc >= 3)
        chk({v[i].nm, "_alu"},
            32'({ex_fun, ex_s1, ex_s2, ex_sgn, ex_ext, ex_lu}),
            32'({v[i].fun, v[i].s1, v[i].s2,
                 v[i].sgn, v[i].ext, v[i].lu}));
    end

    run(I_ADD, 0, 0, 0, 0, -1, '0);
    chk("add_seq", seq, 32'h0000_0124);

    run(I_LW, 0, 0, 0, 3, -1, '0);
    chk("lw_wait_cycles", 32'(cycles), 32'd8);
    chk("lw_wait_seq", seq, 32'h0123_3334);
    chk("lw_wait_mem", 32'(n_mem), 32'd4);
    chk("lw_wait_m2r", 32'(rw_m2r), 32'b01);

    run(I_ADD, 0, 0, 2, 0, -1, '0);
    chk("fetch_wait_cycles", 32'(cycles), 32'd6);
    chk("fetch_wait_irwr", 32'(n_irwr), 32'd1);

    run(I_ADD, 0, 0, 0, 0, 1, 4'b0110);
    chk("irq_cycles", 32'(cycles), 32'd4);
    chk("irq_trap", 32'(last_st), 32'(TRAP));
    MemReady = 1'b1;
    #1;
    chk("irq_pcsrc", 32'(PCSrc), 32'b100);
    chk("irq_trap_outs", 32'({PCWr, RegWr, RegDst, MemToReg}),
        32'b1_1_11_10);
    chk("irq_cause1", 32'(Cause), 32'(C_IRQ1));
    @(negedge clk);
    chk("irq_back_fetch", 32'(State), 32'(FETCH));
    run(32'h0, 0, 0, 0, 0, -1, '0);
    chk("irq_second", 32'(last_st), 32'(L_NOP));
    if (last_st == TRAP) begin
      #1;
      chk("irq_cause2", 32'(Cause), 32'b1010);
      @(negedge clk);
    end else begin
      chk("irq_cause_held", 32'(Cause), 32'(C_IRQ1));
    end

    run(32'hFC000000, 0, 0, 0, 0, -1, '0);
    chk("ill_cycles", 32'(cycles), 32'd2);
    chk("ill_trap", 32'(last_st), 32'(TRAP));
    #1;
    chk("ill_pcsrc", 32'(PCSrc), 32'b101);
    chk("ill_cause", 32'(Cause), 32'b1100);
    @(negedge clk);
    chk("ill_back_fetch", 32'(State), 32'(FETCH));

    Instruct = I_SW; MemReady = 1'b1; PC_sv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    @(negedge clk);
    #1;
    chk("sw_in_mem", 32'({State, MemWr, IorD}), 32'({MEM, 2'b11}));
    IRQ = 4'b0001;
    reset = 1'b0;
    @(negedge clk);
    IRQ = '0;
    #1;
    chk("rst_mid_state", 32'(State), 32'(FETCH));
    chk("rst_mid_wr", 32'({MemWr, RegWr}), 32'b00);
    chk("rst_mid_cause", 32'(Cause), 32'h0);
    reset = 1'b1;
    MemReady = 1'b1;
    run(32'h0, 0, 0, 0, 0, -1, '0);
    chk("rst_mid_pend", 32'(last_st), 32'(FETCH));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
